// File: rtl/nt_block_feeder_pkg.sv
// Shared definitions for the NT-hash block feeder and the MD4 core:
// MD4 initial chaining values, the one-block character limit, the
// feeder state encoding and the byte-swap helper.
package nt_block_feeder_pkg;

  localparam logic [31:0] MD4_INIT_A = 32'h67452301;
  localparam logic [31:0] MD4_INIT_B = 32'hEFCDAB89;
  localparam logic [31:0] MD4_INIT_C = 32'h98BADCFE;
  localparam logic [31:0] MD4_INIT_D = 32'h10325476;

  // 2*27 UTF-16 bytes + 0x80 pad byte still leaves bytes 56..63 free for the length.
  localparam int MAX_BLOCK_CHARS = 27;

  // Cycles from the irdy pulse to a forced error when the core never answers.
  localparam int WATCHDOG_CYCLES = 100;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_PAD,
    ST_FIRE,
    ST_WAIT,
    ST_HOLD
  } feeder_state_t;

  // MD4 works on little-endian words; the digest is presented in byte order.
  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nt_block_assembler.sv
// 64-byte message block register file. Writes one password character as a
// UTF-16LE code unit, inserts the 0x80 pad byte and the 64-bit little-endian
// bit length, and clears back to zero between passwords.
module nt_block_assembler (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr_char,
  input  logic         wr_pad,
  input  logic [4:0]   char_idx,
  input  logic [7:0]   char_byte,
  output logic [511:0] block
);

  logic [5:0]  lo_idx;
  logic [5:0]  hi_idx;
  logic [15:0] bit_len;

  // Character n occupies bytes 2n (ASCII) and 2n+1 (zero high byte).
  assign lo_idx  = {char_idx, 1'b0};
  assign hi_idx  = lo_idx + 6'd1;
  // Message length in bits is 16 per character.
  assign bit_len = {7'd0, char_idx, 4'd0};

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_byte
      localparam logic [5:0] BYTE_IDX = 6'(gi);
      logic [7:0] byte_reg;

      // Per-byte write decode: character, pad marker or length, else hold.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          byte_reg <= 8'h00;
        end else if (wr_char && (BYTE_IDX == lo_idx)) begin
          byte_reg <= char_byte;
        end else if (wr_char && (BYTE_IDX == hi_idx)) begin
          byte_reg <= 8'h00;
        end else if (wr_pad) begin
          if (BYTE_IDX == lo_idx) begin
            byte_reg <= 8'h80;
          end else if (BYTE_IDX == 6'd56) begin
            byte_reg <= bit_len[7:0];
          end else if (BYTE_IDX == 6'd57) begin
            byte_reg <= bit_len[15:8];
          end
        end
      end

      // Message byte i sits at the top of the block, MSB-first.
      assign block[511-8*gi -: 8] = byte_reg;
    end
  endgenerate

endmodule

// File: rtl/nt_block_feeder.sv
// NT-hash block feeder: collects a NUL-terminated ASCII password, builds the
// UTF-16LE MD4-padded block, fires the MD4 core once and holds the digest
// until the consumer takes it.
// Optional: define NT_BLOCK_FEEDER_WATCHDOG_EN to abort a WAIT that sees no
// core result within 100 cycles of the irdy pulse (hash_err=1, digest 0).
module nt_block_feeder
  import nt_block_feeder_pkg::*;
#(
  parameter int MAX_CHARS = MAX_BLOCK_CHARS  // 1..27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         char_valid,
  input  logic [7:0]   char_data,
  output logic         char_ready,
  output logic         md4_irdy,
  output logic [31:0]  md4_state_a,
  output logic [31:0]  md4_state_b,
  output logic [31:0]  md4_state_c,
  output logic [31:0]  md4_state_d,
  output logic [511:0] md4_data,
  input  logic         md4_ordy,
  input  logic [31:0]  md4_newstate_a,
  input  logic [31:0]  md4_newstate_b,
  input  logic [31:0]  md4_newstate_c,
  input  logic [31:0]  md4_newstate_d,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [127:0] hash_digest,
  output logic [4:0]   hash_len,
  output logic         hash_err
);

  localparam logic [4:0] MAX_N = 5'(MAX_CHARS);

  feeder_state_t state_reg, state_next;
  logic [4:0]    count_reg;
  logic          ovf_reg;
  logic [127:0]  digest_reg;
  logic [4:0]    len_reg;
  logic          err_reg;

  logic wr_char, wr_pad, clear_blk, capture, set_ovf, load_err;

`ifdef NT_BLOCK_FEEDER_WATCHDOG_EN
  // irdy cycle + 99 WAIT cycles puts HOLD exactly 100 cycles after the pulse.
  localparam logic [6:0] WD_LAST = 7'(WATCHDOG_CYCLES - 2);
  logic [6:0] wd_reg;

  // Watchdog counts WAIT cycles and restarts whenever WAIT is left.
  always_ff @(posedge clk) begin
    if (rst || (state_reg != ST_WAIT)) begin
      wd_reg <= 7'd0;
    end else begin
      wd_reg <= wd_reg + 7'd1;
    end
  end
`endif

  // The core always starts from the standard MD4 chaining values.
  assign md4_state_a = MD4_INIT_A;
  assign md4_state_b = MD4_INIT_B;
  assign md4_state_c = MD4_INIT_C;
  assign md4_state_d = MD4_INIT_D;

  assign hash_valid  = (state_reg == ST_HOLD);
  assign hash_digest = digest_reg;
  assign hash_len    = len_reg;
  assign hash_err    = err_reg;

  nt_block_assembler u_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_blk),
    .wr_char   (wr_char),
    .wr_pad    (wr_pad),
    .char_idx  (count_reg),
    .char_byte (char_data),
    .block     (md4_data)
  );

  // Next-state and strobe decode; md4_ordy only matters while in WAIT.
  always_comb begin
    state_next = state_reg;
    char_ready = 1'b0;
    md4_irdy   = 1'b0;
    wr_char    = 1'b0;
    wr_pad     = 1'b0;
    clear_blk  = 1'b0;
    capture    = 1'b0;
    set_ovf    = 1'b0;
    load_err   = 1'b0;
    case (state_reg)
      ST_COLLECT: begin
        char_ready = 1'b1;
        if (char_valid) begin
          if (char_data == 8'h00) begin
            state_next = ST_PAD;
          end else if (count_reg < MAX_N) begin
            wr_char = 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (ovf_reg) begin
          load_err   = 1'b1;
          state_next = ST_HOLD;
        end else begin
          wr_pad     = 1'b1;
          state_next = ST_FIRE;
        end
      end
      ST_FIRE: begin
        // The core restarts while irdy is high, so this is a single-cycle pulse.
        md4_irdy   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (md4_ordy) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
        end
`ifdef NT_BLOCK_FEEDER_WATCHDOG_EN
        else if (wd_reg == WD_LAST) begin
          load_err   = 1'b1;
          state_next = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        if (hash_ready) begin
          clear_blk  = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  // State, character count, overflow flag and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_COLLECT;
      count_reg  <= 5'd0;
      ovf_reg    <= 1'b0;
      digest_reg <= 128'd0;
      len_reg    <= 5'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (clear_blk) begin
        count_reg <= 5'd0;
        ovf_reg   <= 1'b0;
      end else begin
        if (wr_char) count_reg <= count_reg + 5'd1;
        if (set_ovf) ovf_reg <= 1'b1;
      end
      if (capture) begin
        digest_reg <= {byteswap32(md4_newstate_a), byteswap32(md4_newstate_b),
                       byteswap32(md4_newstate_c), byteswap32(md4_newstate_d)};
        len_reg    <= count_reg;
        err_reg    <= 1'b0;
      end else if (load_err) begin
        // On overflow the count has saturated at MAX_CHARS.
        digest_reg <= 128'd0;
        len_reg    <= count_reg;
        err_reg    <= 1'b1;
      end
    end
  end

endmodule
